sal_rdwr_arbiter: RTL and testbench
===================================

# sal_rdwr_arbiter

Fair read/write request arbiter between the AXI AW and AR address channels and the DRAM address decoder. Each cycle it selects at most one AW or AR request using a bounded-streak policy, then registers it in a one-entry output stage. The output stage drives a single decoded-request stream with a valid/ready handshake. It replaces fixed write-over-read precedence, bounding the starvation of either direction while still favouring same-direction runs to reduce bus turnaround.

## Interface
Parameters:
- ADDR_W, 32, AXI address width
- ID_W, 4, AXI ID width
- LEN_W, 4, AXI burst length width
- WR_MAX_RUN, 4, max consecutive write grants while a read is waiting (≥1)
- RD_MAX_RUN, 4, max consecutive read grants while a write is waiting (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- aw_valid  in  1  write address request valid
- aw_ready  out  1  write address accepted this cycle
- aw_id / aw_addr / aw_len  in  ID_W / ADDR_W / LEN_W  write request payload
- ar_valid  in  1  read address request valid
- ar_ready  out  1  read address accepted this cycle
- ar_id / ar_addr / ar_len  in  ID_W / ADDR_W / LEN_W  read request payload
- out_valid  out  1  registered request valid toward the decoder
- out_ready  in  1  decoder accepts the request
- out_wr  out  1  1 = write (from AW), 0 = read (from AR)
- out_id / out_addr / out_len  out  ID_W / ADDR_W / LEN_W  registered payload

## Operation
- Output stage states:
  - EMPTY (out_valid=0)
  - FULL (out_valid=1)
- load = !out_valid | out_ready. The stage can take a new request when empty, or when it drains in the same cycle.
- Grant selection (combinational, evaluated only when load=1):
  - Only aw_valid: grant W. Only ar_valid: grant R. Neither: no grant.
  - Both valid: grant last_dir if run_cnt < MAX_RUN(last_dir), otherwise grant the opposite direction.
- aw_ready = load & grant_W; ar_ready = load & grant_R. At most one of the two is high per cycle.
- Ready may depend combinationally on valid and out_ready. No combinational path exists from any payload input to any ready.
- On a grant, at the clock edge:
  - payload and out_wr are captured; out_valid ← 1.
  - Streak: if the granted dir == last_dir, run_cnt ← min(run_cnt+1, MAX_RUN(dir)). Otherwise last_dir ← dir and run_cnt ← 1.
- On load with no grant: out_valid ← 0 (drain to EMPTY). last_dir and run_cnt are held.
- FULL with out_ready=0: all out_* are held stable; both readies are 0.
- run_cnt width = $clog2(max(WR_MAX_RUN, RD_MAX_RUN)+1). It saturates and never wraps.
- Single-requester grants update the streak like any other grant, so a lone direction is never throttled.

## Timing
- Reset (async assert, sync-safe release):
  - out_valid=0; out_wr=0; out_id/out_addr/out_len=0.
  - last_dir=W (1); run_cnt=0.
  - aw_ready=ar_ready=0 while rst_n=0.
- Latency: a request accepted at edge N is presented with out_valid=1 after edge N. This is one cycle of latency.
- Throughput: 1 request/cycle when out_ready is held high (back-to-back grants via load = out_ready).
- Reset mid-FULL: out_valid drops immediately (asynchronously). The held request is discarded.
- Simultaneous drain and load: the new payload replaces the old at the same edge, with no bubble.
- Starvation bound: with both channels continuously valid and out_ready=1, a waiting direction is granted within MAX_RUN(other) cycles.

## Test plan
- Reset: assert rst_n=0 mid-traffic → out_valid=0, all out_* =0, aw_ready=ar_ready=0 in the same cycle; after release, the first contended grant goes to W.
- Single read: ar_valid=1, ar_addr=0x1000, ar_id=3, ar_len=7, out_ready=1 → ar_ready=1 for 1 cycle; next cycle out_valid=1, out_wr=0, out_addr=0x1000, out_id=3, out_len=7.
- Contention, WR_MAX_RUN=RD_MAX_RUN=4, both valid every cycle, out_ready=1 → grant sequence W,W,W,W,R,R,R,R,W,W… with no idle cycles.
- Asymmetric limits, WR_MAX_RUN=2, RD_MAX_RUN=3 → steady-state pattern W,W,R,R,R repeating.
- Backpressure: out_ready=0 for 5 cycles while FULL, with both inputs valid → out_* unchanged, aw_ready=ar_ready=0; raising out_ready → the held request drains and a new grant loads in the same cycle.
- Lone direction: only aw_valid for 10 cycles → 10 consecutive W grants (no throttling), run_cnt saturates at 4; then ar_valid rises with aw_valid still high → next grant is R.

Source files
------------

// File: rtl/sal_rdwr_arbiter.sv
// Read/write address arbiter: picks one AW or AR request per cycle using a
// bounded same-direction streak and registers it in a one-entry output stage.
module sal_rdwr_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 4,
  parameter int LEN_W      = 4,
  parameter int WR_MAX_RUN = 4,
  parameter int RD_MAX_RUN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ID_W-1:0]   aw_id,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [LEN_W-1:0]  aw_len,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [LEN_W-1:0]  ar_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wr,
  output logic [ID_W-1:0]   out_id,
  output logic [ADDR_W-1:0] out_addr,
  output logic [LEN_W-1:0]  out_len
);

  localparam int MAX_RUN = (WR_MAX_RUN > RD_MAX_RUN) ? WR_MAX_RUN : RD_MAX_RUN;
  localparam int CNT_W   = $clog2(MAX_RUN + 1);
  localparam logic [CNT_W-1:0] WR_LIM = CNT_W'(WR_MAX_RUN);
  localparam logic [CNT_W-1:0] RD_LIM = CNT_W'(RD_MAX_RUN);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_last_wr;
  logic [CNT_W-1:0]    r_run_cnt;
  logic                r_wr;
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;

  logic                w_load;
  logic                w_stay;
  logic                w_grant_w;
  logic                w_grant_r;
  logic [CNT_W-1:0]    w_last_lim;

  assign w_load     = (r_state == EMPTY) | out_ready;
  assign w_last_lim = r_last_wr ? WR_LIM : RD_LIM;
  assign w_stay     = (r_run_cnt < w_last_lim);

  // Under contention keep the last direction until its streak limit, then flip.
  always_comb begin
    w_grant_w = 1'b0;
    w_grant_r = 1'b0;
    if (aw_valid && ar_valid) begin
      w_grant_w = (w_stay == r_last_wr);
      w_grant_r = !(w_stay == r_last_wr);
    end else begin
      w_grant_w = aw_valid;
      w_grant_r = ar_valid;
    end
  end

  assign aw_ready  = rst_n & w_load & w_grant_w;
  assign ar_ready  = rst_n & w_load & w_grant_r;

  assign out_valid = (r_state == FULL);
  assign out_wr    = r_wr;
  assign out_id    = r_id;
  assign out_addr  = r_addr;
  assign out_len   = r_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_last_wr <= 1'b1;
      r_run_cnt <= '0;
      r_wr      <= 1'b0;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
    end else if (w_load) begin
      if (w_grant_w || w_grant_r) begin
        r_state <= FULL;
        r_wr    <= w_grant_w;
        r_id    <= w_grant_w ? aw_id   : ar_id;
        r_addr  <= w_grant_w ? aw_addr : ar_addr;
        r_len   <= w_grant_w ? aw_len  : ar_len;
        // Same direction extends the streak (saturating), a switch restarts it.
        if (w_grant_w == r_last_wr) begin
          if (r_run_cnt < w_last_lim) begin
            r_run_cnt <= r_run_cnt + 1'b1;
          end
        end else begin
          r_last_wr <= w_grant_w;
          r_run_cnt <= CNT_W'(1);
        end
      end else begin
        r_state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_sal_rdwr_arbiter.sv
// Randomized bench for sal_rdwr_arbiter: two instances (4/4 and 2/3 streak
// limits) share stimulus and are compared against a grant-history model.
module tb_sal_rdwr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awValid, arValid, outReady;
  logic [3:0]  awId, arId, awLen, arLen;
  logic [31:0] awAddr, arAddr;

  logic        awRdy   [2];
  logic        arRdy   [2];
  logic        oValid  [2];
  logic        oWr     [2];
  logic [3:0]  oId     [2];
  logic [31:0] oAddr   [2];
  logic [3:0]  oLen    [2];

  int checks = 0;
  int errors = 0;

  int maxW [2] = '{4, 2};
  int maxR [2] = '{4, 3};

  // Reference model: full grant history plus the expected output register.
  bit          histDir [2][4096];
  int          histN   [2];
  bit          mValid  [2];
  bit          mWr     [2];
  logic [3:0]  mId     [2];
  logic [31:0] mAddr   [2];
  logic [3:0]  mLen    [2];
  int          obsG    [2];

  always #5 clk = ~clk;

  sal_rdwr_arbiter #(.ADDR_W(32), .ID_W(4), .LEN_W(4), .WR_MAX_RUN(4), .RD_MAX_RUN(4)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(awValid), .aw_ready(awRdy[0]), .aw_id(awId), .aw_addr(awAddr), .aw_len(awLen),
    .ar_valid(arValid), .ar_ready(arRdy[0]), .ar_id(arId), .ar_addr(arAddr), .ar_len(arLen),
    .out_valid(oValid[0]), .out_ready(outReady), .out_wr(oWr[0]),
    .out_id(oId[0]), .out_addr(oAddr[0]), .out_len(oLen[0])
  );

  sal_rdwr_arbiter #(.ADDR_W(32), .ID_W(4), .LEN_W(4), .WR_MAX_RUN(2), .RD_MAX_RUN(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(awValid), .aw_ready(awRdy[1]), .aw_id(awId), .aw_addr(awAddr), .aw_len(awLen),
    .ar_valid(arValid), .ar_ready(arRdy[1]), .ar_id(arId), .ar_addr(arAddr), .ar_len(arLen),
    .out_valid(oValid[1]), .out_ready(outReady), .out_wr(oWr[1]),
    .out_id(oId[1]), .out_addr(oAddr[1]), .out_len(oLen[1])
  );

  // 0 = none, 1 = write, 2 = read; derived by counting the trailing run in history.
  function automatic int expGrant(int k, bit av, bit rv);
    bit lastW;
    int run;
    int lim;
    if (av && !rv) return 1;
    if (rv && !av) return 2;
    if (!av && !rv) return 0;
    lastW = (histN[k] == 0) ? 1'b1 : histDir[k][histN[k]-1];
    run = 0;
    for (int i = histN[k] - 1; i >= 0; i--) begin
      if (histDir[k][i] != lastW) break;
      run++;
    end
    lim = lastW ? maxW[k] : maxR[k];
    if (run < lim) return lastW ? 1 : 2;
    return lastW ? 2 : 1;
  endfunction

  task automatic clearModel();
    for (int k = 0; k < 2; k++) begin
      histN[k]  = 0;
      mValid[k] = 1'b0;
      mWr[k]    = 1'b0;
      mId[k]    = '0;
      mAddr[k]  = '0;
      mLen[k]   = '0;
    end
  endtask

  task automatic randomPayload();
    awId   = 4'($urandom);
    awLen  = 4'($urandom);
    awAddr = $urandom;
    arId   = 4'($urandom);
    arLen  = 4'($urandom);
    arAddr = $urandom;
  endtask

  // One clock: compare readies and outputs at the negedge, advance model at the posedge.
  task automatic cycle();
    int  e    [2];
    bit  load [2];
    int  obs;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      load[k] = !mValid[k] || outReady;
      e[k]    = load[k] ? expGrant(k, awValid, arValid) : 0;
      obs     = (awRdy[k] && arRdy[k]) ? 3 : awRdy[k] ? 1 : arRdy[k] ? 2 : 0;
      obsG[k] = obs;
      checks++;
      if (obs !== e[k]) begin
        errors++;
        $display("[TB] FAIL grant dut%0d: got %0d, expected %0d (t=%0t)", k, obs, e[k], $time);
      end
      checks++;
      if ({oValid[k], oWr[k], oId[k], oAddr[k], oLen[k]} !== {mValid[k], mWr[k], mId[k], mAddr[k], mLen[k]}) begin
        errors++;
        $display("[TB] FAIL outputs dut%0d: got v=%0b wr=%0b id=%0h addr=%08h len=%0h, expected v=%0b wr=%0b id=%0h addr=%08h len=%0h",
                 k, oValid[k], oWr[k], oId[k], oAddr[k], oLen[k], mValid[k], mWr[k], mId[k], mAddr[k], mLen[k]);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (load[k]) begin
        if (e[k] != 0) begin
          mValid[k] = 1'b1;
          mWr[k]    = (e[k] == 1);
          mId[k]    = (e[k] == 1) ? awId   : arId;
          mAddr[k]  = (e[k] == 1) ? awAddr : arAddr;
          mLen[k]   = (e[k] == 1) ? awLen  : arLen;
          if (histN[k] < 4096) begin
            histDir[k][histN[k]] = (e[k] == 1);
            histN[k]++;
          end
        end else begin
          mValid[k] = 1'b0;
        end
      end
    end
    #1;
  endtask

  // Async reset away from the clock edge; outputs and readies must clear immediately.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({oValid[k], oWr[k], oId[k], oAddr[k], oLen[k], awRdy[k], arRdy[k]} !== 43'd0) begin
        errors++;
        $display("[TB] FAIL reset dut%0d: got v=%0b wr=%0b id=%0h addr=%08h len=%0h awr=%0b arr=%0b, expected all 0",
                 k, oValid[k], oWr[k], oId[k], oAddr[k], oLen[k], awRdy[k], arRdy[k]);
      end
    end
    clearModel();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic checkGrant(string name, int k, int expected);
    checks++;
    if (obsG[k] !== expected) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: grant %0d, expected %0d", name, k, obsG[k], expected);
    end
  endtask

  task automatic test_reset();
    awValid = 1'b1; arValid = 1'b1; outReady = 1'b1;
    randomPayload();
    doReset();
    for (int i = 0; i < 6; i++) begin
      outReady = 1'(i % 3 != 2);
      randomPayload();
      cycle();
    end
    doReset();
    outReady = 1'b1;
    randomPayload();
    cycle();
    checkGrant("first_contended", 0, 1);
    checkGrant("first_contended", 1, 1);
  endtask

  task automatic test_single_read();
    doReset();
    awValid = 1'b0; arValid = 1'b1; outReady = 1'b1;
    awId = 4'h1; awAddr = 32'hdead_0000; awLen = 4'h2;
    arId = 4'h3; arAddr = 32'h0000_1000; arLen = 4'h7;
    cycle();
    checkGrant("single_read", 0, 2);
    checks++;
    if ({oValid[0], oWr[0], oId[0], oAddr[0], oLen[0]} !== {1'b1, 1'b0, 4'h3, 32'h0000_1000, 4'h7}) begin
      errors++;
      $display("[TB] FAIL single_read_out: got v=%0b wr=%0b id=%0h addr=%08h len=%0h, expected v=1 wr=0 id=3 addr=00001000 len=7",
               oValid[0], oWr[0], oId[0], oAddr[0], oLen[0]);
    end
    arValid = 1'b0;
    cycle();
    checkGrant("single_read_idle", 0, 0);
    cycle();
  endtask

  task automatic test_contention();
    doReset();
    awValid = 1'b1; arValid = 1'b1; outReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      randomPayload();
      cycle();
      checkGrant("contention_4_4", 0, ((i / 4) % 2 == 0) ? 1 : 2);
      checkGrant("contention_2_3", 1, ((i % 5) < 2) ? 1 : 2);
    end
  endtask

  task automatic test_backpressure();
    awValid = 1'b1; arValid = 1'b1;
    outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      randomPayload();
      cycle();
      checkGrant("backpressure_hold", 0, 0);
    end
    outReady = 1'b1;
    randomPayload();
    cycle();
    checks++;
    if (obsG[0] == 0 || obsG[0] == 3) begin
      errors++;
      $display("[TB] FAIL backpressure_release: grant %0d, expected a single grant", obsG[0]);
    end
    cycle();
  endtask

  task automatic test_lone_write();
    doReset();
    awValid = 1'b1; arValid = 1'b0; outReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      randomPayload();
      cycle();
      checkGrant("lone_write", 0, 1);
    end
    arValid = 1'b1;
    randomPayload();
    cycle();
    checkGrant("lone_then_read", 0, 2);
    checkGrant("lone_then_read", 1, 2);
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 400; i++) begin
      awValid  = 1'($urandom_range(0, 99) < 70);
      arValid  = 1'($urandom_range(0, 99) < 70);
      outReady = 1'($urandom_range(0, 99) < 75);
      randomPayload();
      cycle();
      if (i == 200) doReset();
    end
  endtask

  initial begin
    rst_n = 1'b1;
    awValid = 1'b0; arValid = 1'b0; outReady = 1'b0;
    randomPayload();
    clearModel();
    #2;
    test_reset();
    test_single_read();
    test_contention();
    test_backpressure();
    test_lone_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
